// File: rtl/mips32_multicycle_core.sv
// Multi-cycle MIPS32 core: FSM-sequenced datapath, shared ALU, one unified
// memory port with req/ready handshake so any access may take wait states.
// Ports: clk, rst (async, active-low); mem_req/mem_we/mem_addr/mem_wdata out,
//   mem_rdata/mem_ready in; result (last writeback value), pc_out (next fetch
//   address), state_out (FSM state), halted, illegal (sticky fault flag).
module mips32_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter int          NUM_REGS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] result,
    output logic [31:0] pc_out,
    output logic [2:0]  state_out,
    output logic        halted,
    output logic        illegal
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;
    logic [31:0] gpr_q [NUM_REGS];
    logic [31:0] gpr_d [NUM_REGS];

    logic [5:0]    op, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, dest_idx;
    logic [31:0]   imm_s, imm_z, ea, br_tgt;
    logic          legal;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RW];
    assign rt_idx   = ir_q[16 +: RW];
    assign rd_idx   = ir_q[11 +: RW];
    assign dest_idx = (op == OP_R) ? rd_idx : rt_idx;
    assign imm_s    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_z    = {16'h0000, ir_q[15:0]};
    assign ea       = a_q + imm_s;
    // pc_q already holds PC+4 here, so branch targets are relative to it.
    assign br_tgt   = pc_q + {imm_s[29:0], 2'b00};

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: legal = (funct == F_ADD) || (funct == F_SUB) ||
                          (funct == F_AND) || (funct == F_OR)  ||
                          (funct == F_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        gpr_d     = gpr_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = (rs_idx == '0) ? 32'h0 : gpr_q[rs_idx];
                b_d = (rt_idx == '0) ? 32'h0 : gpr_q[rt_idx];
                if (ir_q == HALT_INSTR) begin
                    state_d = S_HALT;
                end else if (!legal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else if (op == OP_J) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op)
                    OP_R: begin
                        case (funct)
                            F_ADD:   alu_d = a_q + b_q;
                            F_SUB:   alu_d = a_q - b_q;
                            F_AND:   alu_d = a_q & b_q;
                            F_OR:    alu_d = a_q | b_q;
                            F_SLT:   alu_d = {31'h0, $signed(a_q) < $signed(b_q)};
                            default: alu_d = 32'h0;
                        endcase
                    end
                    OP_ADDI: alu_d = a_q + imm_s;
                    OP_ANDI: alu_d = a_q & imm_z;
                    OP_ORI:  alu_d = a_q | imm_z;
                    OP_LW, OP_SW: begin
                        alu_d = ea;
                        if (ea[1:0] != 2'b00) begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        state_d = S_FETCH;
                        if ((a_q == b_q) == (op == OP_BEQ)) begin
                            pc_d = br_tgt;
                        end
                    end
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        alu_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (dest_idx != '0) begin
                    gpr_d[dest_idx] = alu_q;
                end
                result_d = alu_q;
                state_d  = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            gpr_q     <= gpr_d;
        end
    end

    // Gating with rst drops the request the instant reset asserts.
    assign mem_req   = rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = mem_req && (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_wdata = b_q;
    assign result    = result_q;
    assign pc_out    = pc_q;
    assign state_out = state_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_mips32_multicycle_core.sv
// Self-checking bench for mips32_multicycle_core: memory model with data
// wait states, result/store scoreboards, cycle-count and fault scenarios.
module tb_mips32_multicycle_core;
    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] result, pc_out;
    logic [2:0]  state_out;
    logic        halted, illegal;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] st_addr_q [$];
    logic [31:0] st_data_q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          dwait = 0;
    int          cnt = 0;
    int          mem_state_cycles = 0;
    logic        prev_wb = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    mips32_multicycle_core dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .result    (result),
        .pc_out    (pc_out),
        .state_out (state_out),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responder: fetches complete at once, data accesses after dwait.
    always @(negedge clk) begin
        if (!rst) begin
            cnt       = 0;
            mem_ready = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (mem_req) begin
            if (cnt != 0) begin
                check("hold_addr", mem_addr, h_addr);
                check("hold_we", {31'h0, mem_we}, {31'h0, h_we});
                if (h_we) check("hold_wdata", mem_wdata, h_wdata);
            end
            if (cnt == ((state_out == 3'd3) ? dwait : 0)) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    if (st_addr_q.size() == 0) begin
                        check("st_unexp", 32'(st_addr_q.size()), 32'd1);
                    end else begin
                        check("st_addr", mem_addr, st_addr_q.pop_front());
                        check("st_data", mem_wdata, st_data_q.pop_front());
                    end
                end
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    h_addr  = mem_addr;
                    h_we    = mem_we;
                    h_wdata = mem_wdata;
                end
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                cnt++;
            end
        end else begin
            cnt       = 0;
            mem_ready = (dwait == 0);
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    // Result scoreboard: one expected value per writeback.
    always @(negedge clk) begin
        if (!rst) begin
            prev_wb = 1'b0;
        end else begin
            if (prev_wb) begin
                if (exp_q.size() == 0) check("res_unexp", 32'(exp_q.size()), 32'd1);
                else check("result", result, exp_q.pop_front());
            end
            prev_wb = (state_out == 3'd4);
            if (state_out == 3'd3) mem_state_cycles++;
        end
    end

    task automatic do_reset(input int dw);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dwait = dw;
        check("sb_left", 32'(exp_q.size() + st_addr_q.size()), 32'd0);
        exp_q.delete();
        st_addr_q.delete();
        st_data_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_state_cycles = 0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic next_fetch(output int n);
        n = 0;
        while (state_out == 3'd0 && n < 100) begin @(negedge clk); n++; end
        while (state_out != 3'd0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("fetch_timeout", 32'(n), 32'd0);
    endtask

    task automatic step_chk(input string tag, input logic [31:0] pc_exp,
                            input int n_exp);
        int n;
        next_fetch(n);
        check({tag, "_cyc"}, 32'(n), 32'(n_exp));
        check({tag, "_pc"}, pc_out, pc_exp);
    endtask

    task automatic chk_halt(input string tag, input logic ill);
        check({tag, "_halted"}, {31'h0, halted}, 32'd1);
        check({tag, "_illegal"}, {31'h0, illegal}, {31'h0, ill});
        check({tag, "_state"}, {29'h0, state_out}, 32'd5);
    endtask

    initial begin
        int reqs;
        int k;
        rst = 1'b1;
        #3 rst = 1'b0;
        // Reset state and ALU program
        do_reset(0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_state", {29'h0, state_out}, 32'd0);
        check("rst_req", {31'h0, mem_req}, 32'd0);
        check("rst_we", {31'h0, mem_we}, 32'd0);
        check("rst_halt", {30'h0, halted, illegal}, 32'd0);
        check("rst_result", result, 32'h0);
        mem[0]  = 32'h20010005; exp_q.push_back(32'd5);
        mem[1]  = 32'h20010007; exp_q.push_back(32'd7);
        mem[2]  = 32'h2002FFFF; exp_q.push_back(32'hFFFF_FFFF);
        mem[3]  = 32'h00221820; exp_q.push_back(32'd6);
        mem[4]  = 32'h0041202A; exp_q.push_back(32'd1);
        mem[5]  = 32'h00223022; exp_q.push_back(32'd8);
        mem[6]  = 32'h00223824; exp_q.push_back(32'd7);
        mem[7]  = 32'h3429F0F0; exp_q.push_back(32'h0000_F0F7);
        mem[8]  = 32'h304A8001; exp_q.push_back(32'h0000_8001);
        mem[9]  = 32'h00295825; exp_q.push_back(32'h0000_F0F7);
        mem[10] = 32'h0022602A; exp_q.push_back(32'd0);
        mem[11] = 32'h20000009; exp_q.push_back(32'd9);
        mem[12] = 32'h00006820; exp_q.push_back(32'd0);
        mem[13] = 32'hFFFF_FFFF;
        release_rst();
        check("first_req", {31'h0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        check("first_we", {31'h0, mem_we}, 32'd0);
        for (int i = 1; i <= 13; i++) step_chk("alu", 32'(i * 4), 4);
        repeat (2) @(negedge clk);
        chk_halt("a", 1'b0);
        check("a_pc", pc_out, 32'h38);
        reqs = 0;
        repeat (10) begin @(negedge clk); if (mem_req) reqs++; end
        check("a_noreq", 32'(reqs), 32'd0);

        // Store/load with two data wait states
        do_reset(2);
        mem[0] = 32'h20010005; exp_q.push_back(32'd5);
        mem[1] = 32'h08000004;
        mem[4] = 32'hAC010008;
        st_addr_q.push_back(32'h8); st_data_q.push_back(32'd5);
        mem[5] = 32'h8C050008; exp_q.push_back(32'd5);
        mem[6] = 32'hFFFF_FFFF;
        release_rst();
        step_chk("b_addi", 32'h04, 4);
        step_chk("b_j", 32'h10, 2);
        step_chk("b_sw", 32'h14, 6);
        step_chk("b_lw", 32'h18, 7);
        repeat (2) @(negedge clk);
        chk_halt("b", 1'b0);
        check("b_memword", mem[2], 32'd5);

        // Branches and jumps
        do_reset(0);
        mem[0]  = 32'h20010003; exp_q.push_back(32'd3);
        mem[1]  = 32'h08000040;
        mem[4]  = 32'h1021FFFF;
        mem[64] = 32'h14210005;
        mem[65] = 32'h10200005;
        mem[66] = 32'h14200002;
        mem[67] = 32'hFFFF_FFFF;
        mem[68] = 32'hFFFF_FFFF;
        mem[69] = 32'h08000004;
        release_rst();
        step_chk("c_addi", 32'h004, 4);
        step_chk("c_j40", 32'h100, 2);
        step_chk("c_bne_nt", 32'h104, 3);
        step_chk("c_beq_nt", 32'h108, 3);
        step_chk("c_bne_t", 32'h114, 3);
        step_chk("c_j4", 32'h010, 2);
        step_chk("c_beq_self", 32'h010, 3);
        step_chk("c_beq_self2", 32'h010, 3);

        // Halt word and illegal opcodes
        do_reset(0);
        mem[0] = 32'hFFFF_FFFF;
        release_rst();
        repeat (2) @(negedge clk);
        chk_halt("d_halt", 1'b0);
        check("d_halt_pc", pc_out, 32'h4);
        reqs = 0;
        repeat (10) begin @(negedge clk); if (mem_req) reqs++; end
        check("d_noreq", 32'(reqs), 32'd0);

        do_reset(0);
        mem[0] = 32'hF800_0000;
        release_rst();
        repeat (2) @(negedge clk);
        chk_halt("d_op3e", 1'b1);

        do_reset(0);
        mem[0] = 32'h0000_0000;
        release_rst();
        repeat (2) @(negedge clk);
        chk_halt("d_funct0", 1'b1);

        do_reset(0);
        mem[0] = 32'h20020002; exp_q.push_back(32'd2);
        mem[1] = 32'h8C430004;
        release_rst();
        step_chk("d_addi", 32'h4, 4);
        repeat (3) @(negedge clk);
        chk_halt("d_misalign", 1'b1);
        check("d_no_access", 32'(mem_state_cycles), 32'd0);

        // Reset in the middle of a stalled store
        do_reset(3);
        mem[0] = 32'h20010005; exp_q.push_back(32'd5);
        mem[1] = 32'hAC010080;
        release_rst();
        step_chk("e_addi", 32'h4, 4);
        k = 0;
        while (state_out != 3'd3 && k < 50) begin @(negedge clk); k++; end
        check("e_in_mem", {29'h0, state_out}, 32'd3);
        check("e_req_mem", {31'h0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("e_req_drop", {31'h0, mem_req}, 32'd0);
        check("e_pc", pc_out, 32'h0);
        check("e_state", {29'h0, state_out}, 32'd0);
        check("e_result", result, 32'h0);
        mem[0] = 32'h20000009; exp_q.push_back(32'd9);
        mem[1] = 32'h00006820; exp_q.push_back(32'd0);
        mem[2] = 32'hFFFF_FFFF;
        release_rst();
        check("e_no_store", mem[32], 32'h0);
        step_chk("e_addi0", 32'h4, 4);
        step_chk("e_add0", 32'h8, 4);
        repeat (2) @(negedge clk);
        chk_halt("e", 1'b0);
        check("sb_end", 32'(exp_q.size() + st_addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
